// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// datapath select codes, opcode classes, condition codes and the ALU decode.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      BRLINK = 4'd10
   } mc_state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_REG  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Unsupported commands fall back to ADD.
   function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD: alu_decode = ALU_ADD;
         CMD_SUB: alu_decode = ALU_SUB;
         CMD_AND: alu_decode = ALU_AND;
         CMD_ORR: alu_decode = ALU_ORR;
         default: alu_decode = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/condcheck.sv
// Combinational ARM condition-field evaluation against the NZCV flags.
// Encoding 1111 is treated as never-execute.
module condcheck
   import mc_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condex
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      condex = 1'b0;
      case (cond)
         COND_EQ: condex = z;
         COND_NE: condex = ~z;
         COND_CS: condex = c;
         COND_CC: condex = ~c;
         COND_MI: condex = n;
         COND_PL: condex = ~n;
         COND_VS: condex = v;
         COND_VC: condex = ~v;
         COND_HI: condex = c & ~z;
         COND_LS: condex = ~c | z;
         COND_GE: condex = (n == v);
         COND_LT: condex = (n != v);
         COND_GT: condex = ~z & (n == v);
         COND_LE: condex = z | (n != v);
         COND_AL: condex = 1'b1;
         COND_NV: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore-FSM multicycle controller with NZCV flags and predicated writes.
// Define MC_CTRL_BL_EN to add the BRLINK state for branch-with-link.
module mc_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic [2:0] ALUControl,
   output mc_state_t  state
);

   mc_state_t  state_q, state_d;
   logic [3:0] flags_q;
   logic       condex, condex_q;
   logic       exec, flags_we_nz, flags_we_cv;

   condcheck u_condcheck (
      .cond   (Cond),
      .flags  (flags_q),
      .condex (condex)
   );

   assign exec        = (state_q == EXECR) || (state_q == EXECI);
   assign flags_we_nz = exec & Funct[0] & condex_q;
   assign flags_we_cv = flags_we_nz & ((Funct[4:1] == CMD_ADD) || (Funct[4:1] == CMD_SUB));
   assign state       = reset ? FETCH : state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE) condex_q <= condex;
         if (flags_we_nz) flags_q[3:2] <= ALUFlags[3:2];
         if (flags_we_cv) flags_q[1:0] <= ALUFlags[1:0];
      end
   end

   always_comb begin
      state_d    = FETCH;
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_REG;
      ALUSrcB    = SRCB_REG;
      ALUControl = ALU_ADD;
      ImmSrc     = (Op == OP_MEM) ? IMM_MEM : (Op == OP_BR) ? IMM_BR : IMM_DP;
      RegSrc     = {Op == OP_MEM, Op == OP_BR};
      case (state_q)
         FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            state_d   = DECODE;
         end
         DECODE: begin
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            case (Op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
`ifdef MC_CTRL_BL_EN
               OP_BR:   state_d = Funct[4] ? BRLINK : BRANCH;
`else
               OP_BR:   state_d = BRANCH;
`endif
               OP_NOP:  state_d = FETCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB = SRCB_IMM;
            state_d = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = condex_q;
         end
         MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = condex_q;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state_q == EXECI) ? SRCB_IMM : SRCB_REG;
            ALUControl = alu_decode(Funct[4:1]);
            state_d    = ALUWB;
         end
         ALUWB: begin
            RegWrite = condex_q;
            PCWrite  = condex_q & (Rd == 4'd15);
         end
`ifdef MC_CTRL_BL_EN
         // Link write of PC+4 into r14 ahead of the branch target update.
         BRLINK: begin
            ALUSrcA  = SRCA_PC;
            RegSrc   = 2'b11;
            RegWrite = condex_q;
            state_d  = BRANCH;
         end
`endif
         BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = IMM_BR;
            ResultSrc = RES_ALU;
            PCWrite   = condex_q;
         end
         default: state_d = FETCH;
      endcase
      if (reset) begin
         PCWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         IRWrite    = 1'b0;
         AdrSrc     = 1'b0;
         ResultSrc  = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ImmSrc     = 2'b00;
         RegSrc     = 2'b00;
         ALUControl = 3'b000;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: an instruction-level model expands each
// instruction into its per-cycle expected output words.
module tb_mc_controller;
   import mc_pkg::*;

   typedef logic [21:0] word_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
   logic [2:0] ALUControl;
   mc_state_t  state;

   int total = 0;
   int bad = 0;
   logic [3:0] m_flags;
   word_t exp_q[$];

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .state      (state)
   );

   always #5 clk = ~clk;

   function automatic word_t observed();
      return {state, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
              ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
   endfunction

   function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] model_alu(logic [3:0] cmd);
      if (cmd == 4'b0010) return 3'b001;
      if (cmd == 4'b0000) return 3'b010;
      if (cmd == 4'b1100) return 3'b011;
      return 3'b000;
   endfunction

   function automatic word_t exp_word(mc_state_t st, bit pass, logic [1:0] op,
                                      logic [5:0] fn, logic [3:0] rd);
      logic pcw, memw, regw, irw, adr;
      logic [1:0] res, sa, sb, imm, rs;
      logic [2:0] alu;
      {pcw, memw, regw, irw, adr} = 5'b0;
      {res, sa, sb} = 6'b0;
      alu = 3'b000;
      imm = (op == 2'b11) ? 2'b00 : op;
      rs  = {op == 2'b01, op == 2'b10};
      case (st)
         FETCH:  begin irw = 1; pcw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
         DECODE: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
         MEMADR: sb = 2'b01;
         MEMRD:  adr = 1;
         MEMWB:  begin res = 2'b01; regw = pass; end
         MEMWR:  begin adr = 1; memw = pass; end
         EXECR:  alu = model_alu(fn[4:1]);
         EXECI:  begin sb = 2'b01; alu = model_alu(fn[4:1]); end
         ALUWB:  begin regw = pass; pcw = pass && (rd == 4'd15); end
         BRANCH: begin sb = 2'b01; imm = 2'b10; res = 2'b10; pcw = pass; end
         BRLINK: begin sa = 2'b01; rs = 2'b11; regw = pass; end
         default: ;
      endcase
      return {st, pcw, memw, regw, irw, adr, res, sa, sb, imm, rs, alu};
   endfunction

   task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                            input logic [5:0] fn, input logic [3:0] rd,
                            input logic [3:0] af, input int max_cycles);
      mc_state_t sl[$];
      bit pass;
      int n;
      word_t e, o;
      sl = '{FETCH, DECODE};
      case (op)
         2'b01: if (fn[0]) sl = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
                else       sl = '{FETCH, DECODE, MEMADR, MEMWR};
         2'b00: sl = '{FETCH, DECODE, fn[5] ? EXECI : EXECR, ALUWB};
`ifdef MC_CTRL_BL_EN
         2'b10: if (fn[4]) sl = '{FETCH, DECODE, BRLINK, BRANCH};
                else       sl = '{FETCH, DECODE, BRANCH};
`else
         2'b10: sl = '{FETCH, DECODE, BRANCH};
`endif
         default: ;
      endcase
      pass = cond_ok(c, m_flags);
      n = (sl.size() < max_cycles) ? sl.size() : max_cycles;
      for (int i = 0; i < n; i++) exp_q.push_back(exp_word(sl[i], pass, op, fn, rd));
      Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         o = observed();
         e = exp_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, i, o, e);
         end
         @(posedge clk);
         #1;
      end
      if (n == sl.size() && op == 2'b00 && fn[0] && pass) begin
         m_flags[3:2] = af[3:2];
         if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010) m_flags[1:0] = af[1:0];
      end
   endtask

   task automatic hold_reset(input string tag, input int cycles);
      word_t o;
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         o = observed();
         total++;
         if (o !== '0) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected 0", tag, i, o);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      m_flags = 4'b0000;
   endtask

   task automatic test_reset();
      Cond = 4'hE; Op = 2'b00; Funct = 6'b001001; Rd = 4'd2; ALUFlags = 4'hF;
      hold_reset("reset", 3);
      run_instr("first_fetch", 4'hE, 2'b11, 6'd0, 4'd0, 4'h0, 2);
   endtask

   task automatic test_load();
      run_instr("ldr", 4'hE, 2'b01, 6'b011001, 4'd3, 4'h0, 99);
   endtask

   task automatic test_flags_branch();
      run_instr("subs_z", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 99);
      run_instr("beq_taken", 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 99);
      run_instr("bne_not", 4'h1, 2'b10, 6'b100000, 4'd0, 4'h0, 99);
      run_instr("str_ne_fail", 4'h1, 2'b01, 6'b011000, 4'd4, 4'h0, 99);
   endtask

   task automatic test_add_pc();
      run_instr("subs_clr", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0000, 99);
      run_instr("add_pc_al", 4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, 99);
      run_instr("add_pc_eq", 4'h0, 2'b00, 6'b001000, 4'd15, 4'h0, 99);
      run_instr("orr_imm", 4'hE, 2'b00, 6'b111001, 4'd5, 4'b1011, 99);
      run_instr("never", 4'hF, 2'b00, 6'b000100, 4'd6, 4'h0, 99);
   endtask

   task automatic test_bl();
      run_instr("bl", 4'hE, 2'b10, 6'b110000, 4'd0, 4'h0, 99);
   endtask

   task automatic test_reset_mid();
      run_instr("subs_z2", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 99);
      run_instr("abandon", 4'hE, 2'b00, 6'b000101, 4'd2, 4'b1111, 2);
      hold_reset("reset_mid", 1);
      run_instr("beq_after_rst", 4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 99);
   endtask

   task automatic test_random();
      for (int k = 0; k < 120; k++) begin
         run_instr("rand", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 99);
      end
   endtask

   initial begin
      m_flags = 4'b0000;
      test_reset();
      test_load();
      test_flags_branch();
      test_add_pc();
      test_bl();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
